seg_text_writer: RTL and testbench

SEG_TEXT_WRITER -- requirements
Module: seg_text_writer

---
 rtl/seg_text_writer.sv | 138 +++++++++++++
 tb/tb_seg_text_writer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seg_text_writer.sv
// Seven-segment text buffer: accepts ASCII characters one at a time and
// maintains a 64-slot bitmap line with backspace, clear and scrolling.
module seg_text_writer (
    input  logic         clk,
    input  logic         rst,
    input  logic         char_valid,
    input  logic [7:0]   char_code,
    output logic         char_ready,
    output logic [447:0] num,
    output logic [6:0]   count,
    output logic         updated,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;
    typedef enum logic [1:0] {CLS_PRINT, CLS_UNK, CLS_BS, CLS_CLR} cls_t;

    state_t     state;
    logic [7:0] code_q;
    logic [6:0] bm_q;
    cls_t       cls_q;

    logic [7:0] up;
    logic [6:0] dec_bm;
    cls_t       dec_cls;
    logic [5:0] slot;
    logic [8:0] base;

    // Letters are matched case-insensitively by folding lowercase to upper.
    always_comb begin
        up      = char_fold(code_q);
        dec_bm  = 7'h00;
        dec_cls = CLS_PRINT;
        case (up)
            8'h30:   dec_bm = 7'h3F;
            8'h31:   dec_bm = 7'h06;
            8'h32:   dec_bm = 7'h5B;
            8'h33:   dec_bm = 7'h4F;
            8'h34:   dec_bm = 7'h66;
            8'h35:   dec_bm = 7'h6D;
            8'h36:   dec_bm = 7'h7D;
            8'h37:   dec_bm = 7'h07;
            8'h38:   dec_bm = 7'h7F;
            8'h39:   dec_bm = 7'h6F;
            8'h41:   dec_bm = 7'h77;
            8'h42:   dec_bm = 7'h7C;
            8'h43:   dec_bm = 7'h39;
            8'h44:   dec_bm = 7'h5E;
            8'h45:   dec_bm = 7'h79;
            8'h46:   dec_bm = 7'h71;
            8'h48:   dec_bm = 7'h76;
            8'h4C:   dec_bm = 7'h38;
            8'h50:   dec_bm = 7'h73;
            8'h55:   dec_bm = 7'h3E;
            8'h20:   dec_bm = 7'h00;
            8'h2D:   dec_bm = 7'h40;
            8'h5F:   dec_bm = 7'h08;
            8'h08:   dec_cls = CLS_BS;
            8'h0C:   dec_cls = CLS_CLR;
            default: dec_cls = CLS_UNK;
        endcase
    end

    function automatic logic [7:0] char_fold(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A)
            return c & 8'hDF;
        return c;
    endfunction

    // Backspace targets the last occupied slot; print targets the next free one.
    always_comb begin
        slot = (cls_q == CLS_BS) ? 6'(count - 7'd1) : count[5:0];
        base = 9'(slot) * 9'd7;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            code_q     <= 8'h00;
            bm_q       <= 7'h00;
            cls_q      <= CLS_PRINT;
            num        <= '0;
            count      <= 7'd0;
            char_ready <= 1'b1;
            updated    <= 1'b0;
            err        <= 1'b0;
        end else begin
            updated <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        code_q     <= char_code;
                        char_ready <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    bm_q  <= dec_bm;
                    cls_q <= dec_cls;
                    state <= COMMIT;
                end
                COMMIT: begin
                    state      <= IDLE;
                    char_ready <= 1'b1;
                    case (cls_q)
                        CLS_PRINT, CLS_UNK: begin
                            if (count == 7'd64) begin
                                num <= {bm_q, num[447:7]};
                            end else begin
                                num[base +: 7] <= bm_q;
                                count          <= count + 7'd1;
                            end
                            updated <= 1'b1;
                            err     <= (cls_q == CLS_UNK);
                        end
                        CLS_BS: begin
                            if (count == 7'd0) begin
                                err <= 1'b1;
                            end else begin
                                num[base +: 7] <= 7'h00;
                                count          <= count - 7'd1;
                                updated        <= 1'b1;
                            end
                        end
                        default: begin
                            num     <= '0;
                            count   <= 7'd0;
                            updated <= 1'b1;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_text_writer.sv
// Directed testbench for seg_text_writer: handshake timing, print, scroll,
// backspace, unknown, clear and mid-flight reset.
module tb_seg_text_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         char_valid;
    logic [7:0]   char_code;
    logic         char_ready;
    logic [447:0] num;
    logic [6:0]   count;
    logic         updated;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    seg_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_ready (char_ready),
        .num        (num),
        .count      (count),
        .updated    (updated),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [447:0] got,
                       input logic [447:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just before the next
    // accept opportunity, with valid still held.
    task automatic send(input logic [7:0] c, input logic eu, input logic ee);
        int n;
        char_code  = c;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 448'(n < 10), 448'(1));
        @(posedge clk);
        @(negedge clk);
        chk("c1_ready", 448'(char_ready), 448'(0));
        chk("c1_upd", 448'(updated), 448'(0));
        @(negedge clk);
        chk("c2_ready", 448'(char_ready), 448'(0));
        chk("c2_upd", 448'({updated, err}), 448'(0));
        @(negedge clk);
        chk("c3_upd", 448'(updated), 448'(eu));
        chk("c3_err", 448'(err), 448'(ee));
        chk("c3_ready", 448'(char_ready), 448'(1));
    endtask

    logic [447:0] exp;

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_code  = 8'h00;
        #12;
        chk("rst_num", num, '0);
        chk("rst_count", 448'(count), 448'(0));
        chk("rst_ready", 448'(char_ready), 448'(1));
        chk("rst_pulses", 448'({updated, err}), 448'(0));
        @(negedge clk);
        rst = 1'b0;

        send(8'h31, 1, 0);
        send(8'h41, 1, 0);
        send(8'h2D, 1, 0);
        char_valid = 1'b0;
        chk("seq_num", num, 448'({7'h40, 7'h77, 7'h06}));
        chk("seq_count", 448'(count), 448'(3));

        send(8'h0C, 1, 0);
        send(8'h31, 1, 0);
        send(8'h32, 1, 0);
        chk("bs_pre", num, 448'({7'h5B, 7'h06}));
        send(8'h08, 1, 0);
        chk("bs1_num", num, 448'(7'h06));
        chk("bs1_count", 448'(count), 448'(1));
        send(8'h08, 1, 0);
        chk("bs2_count", 448'(count), 448'(0));
        send(8'h08, 0, 1);
        chk("bs3_num", num, '0);
        chk("bs3_count", 448'(count), 448'(0));

        send(8'h61, 1, 0);
        send(8'h5A, 1, 1);
        chk("unk_num", num, 448'({7'h00, 7'h77}));
        chk("unk_count", 448'(count), 448'(2));

        send(8'h0C, 1, 0);
        send(8'h0C, 1, 0);
        chk("clr_empty", num, '0);

        for (int i = 0; i < 64; i++)
            send(8'h38, 1, 0);
        chk("full_num", num, {448{1'b1}});
        chk("full_count", 448'(count), 448'(64));
        send(8'h30, 1, 0);
        exp = {448{1'b1}};
        exp[447:441] = 7'h3F;
        chk("scroll_num", num, exp);
        chk("scroll_count", 448'(count), 448'(64));

        send(8'h0C, 1, 0);
        send(8'h48, 1, 0);
        send(8'h65, 1, 0);
        send(8'h4C, 1, 0);
        send(8'h6C, 1, 0);
        send(8'h50, 1, 0);
        chk("five_num", num,
            448'({7'h73, 7'h38, 7'h38, 7'h79, 7'h76}));
        send(8'h0C, 1, 0);
        chk("clr_num", num, '0);
        chk("clr_count", 448'(count), 448'(0));

        send(8'h31, 1, 0);
        send(8'h32, 1, 0);
        char_code = 8'h37;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        chk("dec_ready", 448'(char_ready), 448'(0));
        rst = 1'b1;
        #1;
        chk("mid_num", num, '0);
        chk("mid_count", 448'(count), 448'(0));
        chk("mid_ready", 448'(char_ready), 448'(1));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_count", 448'(count), 448'(0));
        chk("post_upd", 448'({updated, err}), 448'(0));
        send(8'h33, 1, 0);
        char_valid = 1'b0;
        chk("post_num", num, 448'(7'h4F));
        chk("post_cnt1", 448'(count), 448'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
